// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO pair.
// It runs MULT/MULTU/DIV/DIVU as WIDTH-step shift-add or restoring shift-subtract
// operations, handles MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   start       request strobe; only acted on in IDLE, qualified by funct
//   funct       R-type funct (mult/multu/div/divu/mthi/mtlo; others ignored)
//   rs, rt      operand A (multiplicand / dividend / MT* data), operand B
//   flush       cancel in-flight op; in IDLE also blocks start
//   busy        registered: operation in progress
//   done        registered: one-cycle pulse when HI/LO take an MD result
//   hi, lo      HI and LO registers
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMtlo  = 6'b010011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: multiply high half / divide remainder (remainder < divisor, so WIDTH bits hold it).
  logic [WIDTH-1:0] acc_q, acc_d;
  // wrk: multiplier shifting out / dividend shifting out with quotient shifting in.
  logic [WIDTH-1:0] wrk_q, wrk_d;
  // opb: multiplicand or divisor magnitude.
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    opb_d     = opb_q;
    rs_raw_d  = rs_raw_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    signed_op = (funct == FnMult) || (funct == FnDiv);
    mag_a     = (signed_op && rs[WIDTH-1]) ? -rs : rs;
    mag_b     = (signed_op && rt[WIDTH-1]) ? -rt : rt;

    // Multiply step: add multiplicand if LSB set, then shift {carry, acc, wrk} right.
    mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: shift in next dividend bit, trial-subtract; MSB set means negative.
    rem_sh  = {acc_q, wrk_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, opb_q};
    prod    = neg_quo_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};

    case (state_q)
      StIdle: begin
        if (!flush && start) begin
          case (funct)
            FnMult, FnMultu, FnDiv, FnDivu: begin
              state_d   = StRun;
              cnt_d     = '0;
              acc_d     = '0;
              is_div_d  = funct[1];
              wrk_d     = funct[1] ? mag_a : mag_b;
              opb_d     = funct[1] ? mag_b : mag_a;
              rs_raw_d  = rs;
              neg_quo_d = signed_op && (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_rem_d = signed_op && rs[WIDTH-1];
            end
            FnMthi:  hi_d = rs;
            FnMtlo:  lo_d = rs;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            if (!trial[WIDTH]) begin
              acc_d = trial[WIDTH-1:0];
              wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = rem_sh[WIDTH-1:0];
              wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[WIDTH:1];
            wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            if (opb_q == '0) begin
              // Divide by zero: fixed result, no sign correction.
              hi_d = rs_raw_q;
              lo_d = '1;
            end else begin
              lo_d = neg_quo_q ? -wrk_q : wrk_q;
              hi_d = neg_rem_q ? -acc_q : acc_q;
            end
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      opb_q     <= '0;
      rs_raw_q  <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      opb_q     <= opb_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a cycle-level behavioural model (remaining-cycle
// countdown plus plain arithmetic results) checked every cycle, directed scenarios with
// literal expectations, and a randomized phase.
module tb_muldiv_ctrl;

  localparam logic [5:0] FMULT  = 6'b011000;
  localparam logic [5:0] FMULTU = 6'b011001;
  localparam logic [5:0] FDIV   = 6'b011010;
  localparam logic [5:0] FDIVU  = 6'b011011;
  localparam logic [5:0] FMTHI  = 6'b010001;
  localparam logic [5:0] FMTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct (funct),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] pr;
    sa = $signed(a);
    sb = $signed(b);
    pr = '0;
    case (f)
      FMULT:  pr = sa * sb;
      FMULTU: pr = {32'b0, a} * {32'b0, b};
      FDIV: begin
        if (b == 0) pr = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          r  = sa % sb;
          pr = {r[31:0], q[31:0]};
        end
      end
      FDIVU: begin
        if (b == 0) pr = {a, 32'hFFFF_FFFF};
        else pr = {a % b, a / b};
      end
      default: pr = '0;
    endcase
    return pr;
  endfunction

  // Model: m_left counts edges until the result lands (33 after an accepted MD start).
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (!flush && start) begin
        case (funct)
          FMULT, FMULTU, FDIV, FDIVU: begin
            m_pend <= md_model(funct, rs, rt);
            m_left <= 33;
          end
          FMTHI:   m_hi <= rs;
          FMTLO:   m_lo <= rs;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue an MD op, wait (bounded) for done, check literal results and busy length.
  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    start = 1'b1; funct = f; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) busy_cnt++;
      if (done) got = 1;
      else @(negedge clk);
    end
    chk({name, "_done"}, {31'b0, got}, 32'd1);
    chk({name, "_busylen"}, busy_cnt, 32'd33);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; funct = f; rs = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_md("mult", FMULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("multu_ext", FMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run_md("mult_ext", FMULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_md("div", FDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_ovf", FDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("divu_zero", FDIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF);
    run_md("div_zero", FDIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Flush mid-RUN; an MT* issued during RUN must be ignored.
    mt(FMTHI, 32'h1234);
    mt(FMTLO, 32'h5678);
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h5678);
    @(negedge clk);
    start = 1'b1; funct = FMULT; rs = 32'd5; rt = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; funct = FMTHI; rs = 32'hAAAA;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);
    // flush in IDLE blocks start.
    start = 1'b1; flush = 1'b1; funct = FMTHI; rs = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", hi, 32'h1234);

    // Async reset mid-divide.
    start = 1'b1; funct = FDIV; rs = 32'd1000; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back: second start in the done cycle of the first.
    run_md("b2b_divu", FDIVU, 32'd9, 32'd4, 32'd1, 32'd2);
    start = 1'b1; funct = FMULTU; rs = 32'd3; rt = 32'd5;
    @(negedge clk);
    start = 1'b0;
    begin
      bit got2;
      got2 = 0;
      for (int i = 0; i < 40 && !got2; i++) begin
        if (done) got2 = 1;
        else @(negedge clk);
      end
      chk("b2b_done", {31'b0, got2}, 32'd1);
      chk("b2b_hi", hi, 32'd0);
      chk("b2b_lo", lo, 32'd15);
    end

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: funct = FMULT;
        1: funct = FMULTU;
        2: funct = FDIV;
        3: funct = FDIVU;
        4: funct = FMTHI;
        5: funct = FMTLO;
        6: funct = 6'b100000;
        default: funct = 6'($urandom);
      endcase
      rs = pick_op();
      rt = pick_op();
      flush = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the MIPS32 execute stage. It owns the HI/LO register pair and runs MULT/MULTU/DIV/DIVU as 32-step iterative operations: shift-add for multiply, restoring shift-subtract for divide. It also handles MTHI/MTLO writes and presents HI/LO for MFHI/MFLO. The pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits; the step count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request strobe; sampled only in IDLE
- `funct`  in  6  R-type funct qualifying `start`:
  - 011000 mult
  - 011001 multu
  - 011010 div
  - 011011 divu
  - 010001 mthi
  - 010011 mtlo
  - any other value: `start` ignored
- `rs`  in  WIDTH  operand A (multiplicand / dividend / mthi-mtlo data)
- `rt`  in  WIDTH  operand B (multiplier / divisor)
- `flush`  in  1  cancel the in-flight operation
- `busy`  out  1  operation in progress; pipeline must stall MF*/MT*/MD issue
- `done`  out  1  one-cycle pulse when HI/LO take a new MD result
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States:
  - IDLE
  - RUN: 32 iteration cycles
  - FIX: sign correction and HI/LO write
- Reset (async, `rst_n`=0): state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0; step counter 0; internal accumulators cleared.
- IDLE:
  - `start`=1 with mult/multu/div/divu: latch operands → RUN, counter=0.
  - Signed ops (mult, div) latch magnitudes and record `neg_q` = sign(rs)^sign(rt) and `neg_r` = sign(rs).
  - Unsigned ops latch operands as-is with `neg_q`=`neg_r`=0.
- IDLE, `start`=1 with mthi/mtlo: `hi`/`lo` ← `rs` at that edge. Stay IDLE, no `busy`, no `done`.
- RUN:
  - One multiply or divide step per cycle.
  - Counter increments each cycle; at counter=31 → FIX.
- Multiply:
  - 64-bit {acc, mplr}; each step adds the multiplicand to acc if mplr[0], then shifts right 1.
- Divide:
  - Restoring; remainder register is WIDTH+1 bits.
  - Each step shifts in the dividend MSB, trial-subtracts the divisor, sets the quotient bit if the result is non-negative, otherwise restores.
- Divisor zero: the iteration still runs the full 32 steps. In FIX, the result is forced to `hi`=rs (original, unsigned view) and `lo`={WIDTH{1}}, for both div and divu, with no sign correction.
- FIX:
  - mult: if `neg_q`, the 64-bit product is two's-complement negated. {hi, lo} ← product.
  - div: `lo` ← quotient, negated if `neg_q`. `hi` ← remainder, negated if `neg_r`.
  - Then → IDLE, with `done`=1 for that one cycle.
- Signed overflow case: div 0x80000000 / 0xFFFFFFFF yields `lo`=0x80000000, `hi`=0 (magnitude arithmetic, `neg_q`=0).
- Flush:
  - `flush`=1 in RUN or FIX → IDLE at the next edge.
  - `hi`/`lo` are unchanged and `done` stays 0.
  - `flush` has priority over FIX completion.
  - `flush` in IDLE blocks `start` that cycle.
- `start` while not IDLE is ignored (no queuing). Priority in IDLE: `flush` > `start`.

## Timing
- MD op: `start` sampled at edge E0.
  - `busy`=1 from after E0 through the cycle ending at edge E33.
  - RUN covers E1..E32; FIX write happens at E33.
  - `hi`/`lo` hold the new values and `done`=1 during the cycle after E33; `busy`=0 in that same cycle.
  - Total latency is 33 cycles from the start edge to result-valid.
- A new `start` is accepted in the `done` cycle (back-to-back ops, one idle cycle between RUN phases).
- MT*: single-cycle; the new value is visible the cycle after the `start` edge.
- `busy` and `done` are registered state decodes: no combinational path from inputs.
- `hi`/`lo` change only at an MT* edge or at E33; they are stable otherwise, including throughout RUN.
- Reset mid-RUN: immediate return to IDLE with all outputs 0.

## Test plan
- Signed multiply: mult rs=7, rt=0xFFFFFFFD (−3) → after 33 cycles `done` pulse, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- Unsigned multiply extreme: multu 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then mult with the same operands → `hi`=0, `lo`=1.
- Signed divide: div rs=0xFFFFFFF9 (−7), rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: divu rs=100, rt=0 → `hi`=0x64, `lo`=0xFFFFFFFF, with the full 33-cycle latency.
- Flush: preload `hi`=0x1234 and `lo`=0x5678 via mthi/mtlo; start mult; assert `flush` at cycle 10 → IDLE next cycle, no `done`, `hi`/`lo` still 0x1234/0x5678. A `start` (mthi, rs=0xAAAA) issued in RUN is ignored.
- Reset/back-to-back:
  - Async `rst_n` low mid-div → all outputs 0 immediately.
  - After release, divu 9/4 followed by `start` in its `done` cycle with multu 3×5 → `lo`=2 and `hi`=1 first, then `hi`=0 and `lo`=15.
